// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer that shares one combinational 32-bit ALU between two
// requesters, returning result, zero flag and illegal-code error over valid/ready.
module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTR_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_op1,
   input  logic [DATA_W-1:0] req0_op2,
   input  logic [CTR_W-1:0]  req0_ctr,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_op1,
   input  logic [DATA_W-1:0] req1_op2,
   input  logic [CTR_W-1:0]  req1_ctr,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   output logic [CTR_W-1:0]  alu_ctr,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp0_err,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic              rsp1_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state_q, state_d;
   logic                prio_q, prio_d;
   logic                id_q, id_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                zero_q, zero_d;
   logic [DATA_W-1:0]   src1_q, src1_d;
   logic [DATA_W-1:0]   src2_q, src2_d;
   logic [CTR_W-1:0]    ctr_q, ctr_d;

   logic                grant;
   logic                accept;
   logic [CTR_W-1:0]    sel_ctr;

   function automatic logic is_illegal(input logic [CTR_W-1:0] c);
      return (c == CTR_W'(3'b010)) || (c == CTR_W'(3'b011)) || (c == CTR_W'(3'b111));
   endfunction

   // With both valid the pointer decides; otherwise whichever is valid wins.
   assign grant      = (req0_valid && req1_valid) ? prio_q : req1_valid;
   assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
   assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;
   assign accept     = req0_ready || req1_ready;
   assign sel_ctr    = grant ? req1_ctr : req0_ctr;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      id_d    = id_q;
      err_d   = err_q;
      res_d   = res_q;
      zero_d  = zero_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      ctr_d   = ctr_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               src1_d  = grant ? req1_op1 : req0_op1;
               src2_d  = grant ? req1_op2 : req0_op2;
               ctr_d   = sel_ctr;
               id_d    = grant;
               err_d   = is_illegal(sel_ctr);
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_d   = alu_result;
            zero_d  = alu_zero;
            state_d = RESP;
         end
         RESP: begin
            if (id_q ? rsp1_ready : rsp0_ready) begin
               prio_d  = !id_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         src1_q  <= '0;
         src2_q  <= '0;
         ctr_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         id_q    <= id_d;
         err_q   <= err_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         ctr_q   <= ctr_d;
      end
   end

   assign alu_src1 = src1_q;
   assign alu_src2 = src2_q;
   assign alu_ctr  = ctr_q;
   assign busy     = (state_q != IDLE);

   // One shared capture register; the idle requester's outputs are forced to zero.
   assign rsp0_valid  = (state_q == RESP) && !id_q;
   assign rsp1_valid  = (state_q == RESP) &&  id_q;
   assign rsp0_result = rsp0_valid ? res_q : '0;
   assign rsp1_result = rsp1_valid ? res_q : '0;
   assign rsp0_zero   = rsp0_valid && zero_q;
   assign rsp1_zero   = rsp1_valid && zero_q;
   assign rsp0_err    = rsp0_valid && err_q;
   assign rsp1_err    = rsp1_valid && err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: behavioural ALU, response scoreboard fed at
// accept time and drained by a negedge monitor on each response handshake.
module tb_alu_share_arbiter;

   localparam int DATA_W = 32;
   localparam int CTR_W  = 3;

   logic              clk, rst_n;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [DATA_W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [CTR_W-1:0]  req0_ctr, req1_ctr;
   logic [DATA_W-1:0] alu_src1, alu_src2, alu_result;
   logic [CTR_W-1:0]  alu_ctr;
   logic              alu_zero;
   logic              rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
   logic              rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
   logic [DATA_W-1:0] rsp0_result, rsp1_result;
   logic              busy;

   typedef struct {
      bit                id;
      logic [DATA_W-1:0] result;
      logic              zero;
      logic              err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_share_arbiter #(.DATA_W(DATA_W), .CTR_W(CTR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctr(req0_ctr),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctr(req1_ctr),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctr(alu_ctr),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-cycle ALU; illegal codes yield 0.
   always_comb begin
      alu_result = '0;
      case (alu_ctr)
         3'b000:  alu_result = alu_src1 & alu_src2;
         3'b001:  alu_result = alu_src1 | alu_src2;
         3'b100:  alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
         3'b101:  alu_result = alu_src1 + alu_src2;
         3'b110:  alu_result = alu_src1 - alu_src2;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic score(input bit id, input logic [DATA_W-1:0] res, input logic z, input logic e);
      exp_t x;
      if (exp_q.size() == 0) begin
         check($sformatf("unexpected_rsp%0d", id), 32'd1, 32'd0);
      end else begin
         x = exp_q.pop_front();
         check("rsp_id", 32'(id), 32'(x.id));
         check($sformatf("rsp%0d_result", id), res, x.result);
         check($sformatf("rsp%0d_zero", id), 32'(z), 32'(x.zero));
         check($sformatf("rsp%0d_err", id), 32'(e), 32'(x.err));
      end
   endtask

   // Monitor: a handshake is sampled once, on the negedge before the accepting edge.
   always @(negedge clk) begin
      if (rsp0_valid) check("rsp1_idle_while_rsp0", {rsp1_valid, rsp1_zero, rsp1_err} | rsp1_result, 32'd0);
      if (rsp1_valid) check("rsp0_idle_while_rsp1", {rsp0_valid, rsp0_zero, rsp0_err} | rsp0_result, 32'd0);
      if (rsp0_valid && rsp0_ready) score(1'b0, rsp0_result, rsp0_zero, rsp0_err);
      if (rsp1_valid && rsp1_ready) score(1'b1, rsp1_result, rsp1_zero, rsp1_err);
   end

   task automatic drive(input bit id, input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c);
      if (id) begin
         req1_valid = v; req1_op1 = a; req1_op2 = b; req1_ctr = c;
      end else begin
         req0_valid = v; req0_op1 = a; req0_op2 = b; req0_ctr = c;
      end
   endtask

   function automatic bit rdy(input bit id);
      return id ? req1_ready : req0_ready;
   endfunction

   // Wait (bounded) for ready on requester id, push the expected response, cross the edge.
   task automatic accept(input bit id, input logic [31:0] r, input logic z, input logic e);
      bit   ok;
      exp_t x;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (rdy(id)) ok = 1'b1;
         else @(posedge clk);
      end
      if (!ok) begin
         check($sformatf("accept%0d_timeout", id), 32'd0, 32'd1);
      end else begin
         check($sformatf("accept%0d_exclusive", id), 32'(rdy(!id)), 32'd0);
         x.id = id; x.result = r; x.zero = z; x.err = e;
         exp_q.push_back(x);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (!busy) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      #22;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_alu_src", alu_src1 | alu_src2 | 32'(alu_ctr), 32'd0);
      check("reset_rsp", {rsp0_valid, rsp0_zero, rsp0_err, rsp1_valid, rsp1_zero, rsp1_err}
                         | rsp0_result | rsp1_result, 32'd0);
      check("reset_ready_no_valid", {req0_ready, req1_ready}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single add 5+7: ready same cycle, response two cycles after accept.
      drive(1'b0, 1'b1, 32'd5, 32'd7, 3'b101);
      #1;
      check("add_ready_same_cycle", 32'(req0_ready), 32'd1);
      accept(1'b0, 32'd12, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      check("add_exec_no_rsp", {rsp0_valid, busy}, 32'b01);
      check("add_alu_src1", alu_src1, 32'd5);
      check("add_alu_src2", alu_src2, 32'd7);
      check("add_alu_ctr", 32'(alu_ctr), 32'b101);
      @(posedge clk);
      #1;
      check("add_rsp_latency", {rsp0_valid, rsp1_valid}, 32'b10);
      wait_idle();

      // Both valid after reset: req0 first, then alternation while both stay valid.
      do_reset();
      drive(1'b0, 1'b1, 32'hF0, 32'h3C, 3'b000);
      drive(1'b1, 1'b1, 32'hF0, 32'h0F, 3'b001);
      #1;
      check("both_grant_req0", {req0_ready, req1_ready}, 32'b10);
      accept(1'b0, 32'h30, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'h11, 32'h22, 3'b101);
      accept(1'b1, 32'hFF, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 32'h10, 32'h03, 3'b110);
      accept(1'b0, 32'h33, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      accept(1'b1, 32'h0D, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_idle();

      // Sub 9-9 and slt 3<8 on req1.
      drive(1'b1, 1'b1, 32'd9, 32'd9, 3'b110);
      accept(1'b1, 32'd0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_idle();
      drive(1'b1, 1'b1, 32'd3, 32'd8, 3'b100);
      accept(1'b1, 32'd1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_idle();

      // Illegal code 011 on req0.
      drive(1'b0, 1'b1, 32'h1234, 32'h5678, 3'b011);
      accept(1'b0, 32'd0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_idle();

      // Backpressure: rsp0 held for 4 cycles while req1 waits.
      rsp0_ready = 1'b0;
      drive(1'b0, 1'b1, 32'd1, 32'd1, 3'b101);
      accept(1'b0, 32'd2, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      drive(1'b1, 1'b1, 32'd2, 32'd2, 3'b101);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         check("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
         check("bp_rsp0_result", rsp0_result, 32'd2);
         check("bp_req1_blocked", 32'(req1_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      rsp0_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_req1_next_idle", 32'(req1_ready), 32'd1);
      accept(1'b1, 32'd4, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_idle();

      // Async reset during EXEC discards the operation.
      drive(1'b0, 1'b1, 32'd4, 32'd4, 3'b101);
      #1;
      check("rst_op_ready", 32'(req0_ready), 32'd1);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      check("rst_op_in_exec", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_alu", alu_src1 | alu_src2 | 32'(alu_ctr), 32'd0);
      check("rst_async_rsp", {rsp0_valid, rsp0_zero, rsp0_err, rsp1_valid} | rsp0_result, 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_resume_idle", 32'(busy), 32'd0);
      drive(1'b1, 1'b1, 32'd2, 32'd3, 3'b101);
      accept(1'b1, 32'd5, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
